// File: rtl/mem_access_ctrl.sv
// MEM-stage access controller: zero-penalty cache hits, stalling load-miss refill
// and write-through stores with cache-line invalidation.
module mem_access_ctrl #(
  parameter int DW      = 32,
  parameter int RAM_LAT = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          memRead_i,
  input  logic          memWrite_i,
  input  logic [DW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          hit_i,
  input  logic [DW-1:0] cacheData_i,
  input  logic [DW-1:0] ramData_i,
  output logic          ramReq_o,
  output logic          ramWe_o,
  output logic [DW-1:0] ramAddr_o,
  output logic [DW-1:0] ramWdata_o,
  output logic          cacheFill_o,
  output logic          cacheInval_o,
  output logic [DW-1:0] fillAddr_o,
  output logic [DW-1:0] fillData_o,
  output logic [DW-1:0] data_o,
  output logic          stall_o,
  output logic [15:0]   missCount_o
);

  localparam int CW = $clog2(RAM_LAT + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(RAM_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_MISS_WAIT  = 2'd1,
    S_FILL       = 2'd2,
    S_STORE_WAIT = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] data_q, data_d;
  logic [15:0]   miss_cnt_q, miss_cnt_d;
  logic [DW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;

  assign ramAddr_o   = ram_addr_q;
  assign ramWdata_o  = ram_wdata_q;
  assign fillAddr_o  = ram_addr_q;
  assign fillData_o  = data_q;
  assign missCount_o = miss_cnt_q;

  // Next-state, datapath updates and combinational stall/strobe outputs
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    miss_cnt_d   = miss_cnt_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    ramReq_o     = 1'b0;
    ramWe_o      = 1'b0;
    cacheFill_o  = 1'b0;
    cacheInval_o = 1'b0;
    stall_o      = 1'b0;
    data_o       = cacheData_i;

    case (state_q)
      S_IDLE: begin
        // A load takes priority over a simultaneous store
        if (memRead_i) begin
          if (!hit_i) begin
            stall_o    = 1'b1;
            ram_addr_d = addr_i;
            cnt_d      = CNT_LOAD;
            state_d    = S_MISS_WAIT;
            if (miss_cnt_q != 16'hFFFF) begin
              miss_cnt_d = miss_cnt_q + 16'd1;
            end else begin
              miss_cnt_d = miss_cnt_q;
            end
          end else begin
            state_d = S_IDLE;
          end
        end else if (memWrite_i) begin
          stall_o      = 1'b1;
          cacheInval_o = 1'b1;
          ram_addr_d   = addr_i;
          ram_wdata_d  = wdata_i;
          cnt_d        = CNT_LOAD;
          state_d      = S_STORE_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MISS_WAIT: begin
        ramReq_o = 1'b1;
        stall_o  = 1'b1;
        if (cnt_q == '0) begin
          data_d  = ramData_i;
          state_d = S_FILL;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_FILL: begin
        cacheFill_o = 1'b1;
        data_o      = data_q;
        state_d     = S_IDLE;
      end
      S_STORE_WAIT: begin
        ramReq_o = 1'b1;
        ramWe_o  = 1'b1;
        // The store retires in the last write cycle
        if (cnt_q == '0) begin
          stall_o = 1'b0;
          state_d = S_IDLE;
        end else begin
          stall_o = 1'b1;
          cnt_d   = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      data_q      <= '0;
      miss_cnt_q  <= 16'd0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      miss_cnt_q  <= miss_cnt_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Controller for the MEM stage that sits between the pipeline, the two-way associative cache and the data RAM. Loads that hit the cache complete with zero penalty. Load misses stall the pipeline, run a fixed-latency RAM read, refill the cache and then release the load result. Stores are write-through: the controller invalidates the cached line and stalls for the RAM write latency. `stall_o` drives the pipeline enables (`en = ~stall_o`) in the top level.

## Interface
Parameters:
- `DW`, 32, data and address width.
- `RAM_LAT`, 3, RAM access latency in cycles; legal range 1..15.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `memRead_i`  in  1  MEM-stage instruction is a load.
- `memWrite_i`  in  1  MEM-stage instruction is a store.
- `addr_i`  in  DW  MEM-stage effective address (ALU result).
- `wdata_i`  in  DW  store data.
- `hit_i`  in  1  combinational cache lookup hit for `addr_i`.
- `cacheData_i`  in  DW  cache read data.
- `ramData_i`  in  DW  RAM read data; valid in the last MISS_WAIT cycle.
- `ramReq_o`  out  1  RAM access active.
- `ramWe_o`  out  1  RAM write enable.
- `ramAddr_o`  out  DW  RAM address (latched).
- `ramWdata_o`  out  DW  RAM write data (latched).
- `cacheFill_o`  out  1  one-cycle cache line fill strobe.
- `cacheInval_o`  out  1  one-cycle invalidate strobe for `addr_i`.
- `fillAddr_o`  out  DW  fill address.
- `fillData_o`  out  DW  fill data.
- `data_o`  out  DW  load result passed to the MEM/WB register.
- `stall_o`  out  1  freeze PC and all pipeline registers.
- `missCount_o`  out  16  saturating load-miss counter.

## Operation
States: IDLE, MISS_WAIT, FILL, STORE_WAIT. A latency counter `cnt` is sized to hold `RAM_LAT`.

**IDLE**
- `memRead_i & hit_i`: `data_o = cacheData_i`, `stall_o = 0`, state stays IDLE.
- `memRead_i & ~hit_i`:
  - `stall_o = 1` combinationally in the same cycle.
  - Latch `addr_i` into `ramAddr_o` / `fillAddr_o`; load `cnt = RAM_LAT-1`.
  - Increment `missCount_o`; it saturates at 16'hFFFF.
  - Next state MISS_WAIT.
- `memWrite_i` (and not `memRead_i`):
  - `stall_o = 1` combinationally.
  - `cacheInval_o = 1` this cycle, regardless of `hit_i`.
  - Latch address and `wdata_i`; load `cnt = RAM_LAT-1`.
  - Next state STORE_WAIT.
- `memRead_i & memWrite_i` together: treated as a load; the store is ignored.
- Neither asserted: `data_o = cacheData_i`, `stall_o = 0`.

**MISS_WAIT**
- Outputs: `ramReq_o = 1`, `ramWe_o = 0`, `stall_o = 1`.
- `cnt` decrements each cycle.
- When `cnt == 0`, capture `ramData_i` into the data register and go to FILL.

**FILL**
- `cacheFill_o = 1`; `fillData_o` = captured data.
- `data_o` = captured data; `stall_o = 0`, so the load retires this cycle.
- `memRead_i` / `hit_i` are ignored; the cache is not yet updated.
- Next state IDLE.

**STORE_WAIT**
- Outputs: `ramReq_o = 1`, `ramWe_o = 1`.
- `stall_o = 1` while `cnt != 0`; `stall_o = 0` when `cnt == 0`, so the store retires.
- `cnt` decrements each cycle; at `cnt == 0` go to IDLE.

**Output rules**
- `ramAddr_o` and `ramWdata_o` hold their latched values outside active states.
- `ramReq_o`, `ramWe_o`, `cacheFill_o` and `cacheInval_o` are 0 whenever not stated above.

## Timing
- Reset values: state IDLE, `cnt = 0`, data register 0, `missCount_o = 0`, `ramAddr_o = 0`, `ramWdata_o = 0`. All strobes and `ramReq_o` are 0.
- Reset wins over any transition. Reset mid-miss or mid-store abandons the access at the next edge: no fill, no retire.
- Load hit: 0 stall cycles.
- Load miss detected in cycle 0:
  - `stall_o` = 1 in cycles 0..`RAM_LAT`.
  - FILL occurs in cycle `RAM_LAT+1`.
  - Penalty is `RAM_LAT+1` cycles.
- Store accepted in cycle 0:
  - `stall_o` = 1 in cycles 0..`RAM_LAT-1`.
  - `stall_o` = 0 in cycle `RAM_LAT` (last STORE_WAIT cycle).
  - Penalty is `RAM_LAT` cycles.
- `RAM_LAT = 1`: MISS_WAIT and STORE_WAIT each last exactly one cycle.
- Back-to-back accesses: a new request is only evaluated in IDLE. The instruction arriving after FILL or after the store retires is examined in the following cycle.

## Test plan
- **Reset:** hold `rst` 2 cycles mid-MISS_WAIT -> next cycle state IDLE, `stall_o = 0`, `ramReq_o = 0`, `missCount_o = 0`, no `cacheFill_o`.
- **Load hit:** `memRead_i = 1`, `hit_i = 1`, `cacheData_i = 32'hDEADBEEF` -> same cycle `data_o = 32'hDEADBEEF`, `stall_o = 0`, `missCount_o` unchanged.
- **Load miss (RAM_LAT = 3):** `addr_i = 32'h100`, `hit_i = 0`, `ramData_i = 32'h12345678` in the 3rd MISS_WAIT cycle -> `stall_o` high 4 cycles. Then one cycle with `cacheFill_o = 1`, `fillAddr_o = 32'h100`, `data_o = 32'h12345678`, `stall_o = 0`; `missCount_o = 1`.
- **Store:** `memWrite_i = 1`, `addr_i = 32'h200`, `wdata_i = 32'hA5A5A5A5` -> `cacheInval_o` pulses in cycle 0; `ramWe_o = 1` with the latched address and data for 3 cycles; `stall_o` high for 3 cycles.
- **Simultaneous read + write:** both asserted with `hit_i = 0` -> load miss sequence runs, `ramWe_o` never asserted.
- **Counter saturation:** preload 65535 misses (or force the count) -> one more miss keeps `missCount_o = 16'hFFFF`.
